// File: rtl/alu_issue_scheduler_if.sv
// Handshake bundle for alu_issue_scheduler: host push port, ALU issue/done port
// and result port. The scheduler uses the slave view, its environment the master view.
interface alu_issue_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [OPW-1:0]   in_op;

  logic             alu_start;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic             alu_done;
  logic [WIDTH-1:0] alu_result;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_a, in_b, in_op, alu_done, alu_result, out_ready,
    input  in_ready, alu_start, alu_a, alu_b, alu_op, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, alu_done, alu_result, out_ready,
    output in_ready, alu_start, alu_a, alu_b, alu_op, out_valid, out_data
  );
endinterface

// File: rtl/alu_issue_scheduler.sv
// Queues (a, b, op) triples in a small FIFO and issues them one at a time to the
// shared ALU with a start/done handshake, returning each result on a valid/ready port.
module alu_issue_scheduler #(
  parameter int WIDTH   = 8,
  parameter int OPW     = 3,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  alu_issue_scheduler_if.slave   bus,
  output logic                   busy,
  output logic                   err_timeout,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
  } entry_t;

  state_e           state_q, state_d;
  entry_t           mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [TW-1:0]    timer_q, timer_d;
  entry_t           issue_q, issue_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             err_q, err_d;

  logic   in_ready;
  logic   push;
  logic   pop;
  entry_t in_entry;
  entry_t head;

  assign in_ready = count_q < CW'(DEPTH);
  assign push     = bus.in_valid && in_ready;
  assign in_entry = {bus.in_a, bus.in_b, bus.in_op};
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    timer_d     = timer_q;
    issue_d     = issue_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_d       = err_q;
    pop         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ena && count_q != '0) begin
          pop     = 1'b1;
          issue_d = head;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done in the final WAIT cycle still wins over the abort.
        if (bus.alu_done) begin
          out_data_d  = bus.alu_result;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else if (timer_q >= TW'(TIMEOUT - 1)) begin
          timer_d     = TW'(TIMEOUT);
          out_data_d  = '1;
          out_valid_d = 1'b1;
          err_d       = 1'b1;
          state_d     = S_HOLD;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      issue_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      issue_q     <= issue_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  // NOTE: FIFO storage is not reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  assign bus.in_ready  = in_ready;
  assign bus.alu_start = (state_q == S_ISSUE);
  assign bus.alu_a     = issue_q.a;
  assign bus.alu_b     = issue_q.b;
  assign bus.alu_op    = issue_q.op;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  assign busy        = (state_q != S_IDLE) || (count_q != '0);
  assign err_timeout = err_q;
  assign fifo_count  = count_q;
endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Self-checking bench for alu_issue_scheduler: the bench plays host, ALU and consumer,
// and a transaction-level model predicts issue order, timing and results.
module tb_alu_issue_scheduler;
  localparam int WIDTH   = 8;
  localparam int OPW     = 3;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
  } trip_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       busy;
  logic       err_timeout;
  logic [2:0] fifo_count;

  alu_issue_scheduler_if #(.WIDTH(WIDTH), .OPW(OPW)) dut_if ();

  alu_issue_scheduler #(
    .WIDTH(WIDTH), .OPW(OPW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .bus(dut_if),
    .busy(busy),
    .err_timeout(err_timeout),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  trip_t push_q[$];
  trip_t fifo_m[$];
  int    lat_q[$];

  bit         inflight = 0;
  trip_t      cur;
  int         start_cyc = 0;
  int         rise_cyc = 0;
  int         done_cyc = -1;
  logic [7:0] exp_data;
  bit         exp_to = 0;
  bit         err_m = 0;
  int         hold_cnt = 0;
  int         ready_delay = 0;
  int         ready_delay_cfg = 0;
  bit         noise_en = 0, gap_en = 0, rand_ena = 0, rand_ready = 0, rand_lat = 0;

  function automatic logic [7:0] alu_fn(trip_t t);
    case (t.op)
      3'd0:    return t.a + t.b;
      3'd1:    return t.a - t.b;
      3'd2:    return t.a & t.b;
      3'd3:    return t.a | t.b;
      3'd4:    return t.a ^ t.b;
      3'd5:    return t.a << t.b[2:0];
      3'd6:    return t.a >> t.b[2:0];
      default: return ~t.a;
    endcase
  endfunction

  function automatic trip_t rand_trip();
    trip_t t;
    t.a  = 8'($urandom);
    t.b  = 8'($urandom);
    t.op = 3'($urandom);
    return t;
  endfunction

  task automatic drive_inputs();
    bit    ov_m, in_wait;
    trip_t t;
    ov_m    = inflight && cyc >= rise_cyc;
    in_wait = inflight && cyc > start_cyc && cyc < rise_cyc;
    if (push_q.size() != 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
      t = push_q[0];
      dut_if.in_valid = 1'b1;
      dut_if.in_a = t.a; dut_if.in_b = t.b; dut_if.in_op = t.op;
    end else begin
      dut_if.in_valid = 1'b0;
      dut_if.in_a = 8'($urandom); dut_if.in_b = 8'($urandom); dut_if.in_op = 3'($urandom);
    end
    if (inflight && cyc == done_cyc) begin
      dut_if.alu_done = 1'b1;
      dut_if.alu_result = alu_fn(cur);
    end else if (noise_en && !in_wait && $urandom_range(0, 2) == 0) begin
      dut_if.alu_done = 1'b1;
      dut_if.alu_result = 8'($urandom);
    end else begin
      dut_if.alu_done = 1'b0;
      dut_if.alu_result = 8'($urandom);
    end
    if (ov_m) begin
      dut_if.out_ready = (hold_cnt >= ready_delay);
      hold_cnt++;
    end else begin
      dut_if.out_ready = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    if (rand_ena) ena = ($urandom_range(0, 3) != 0);
  endtask

  // One clock: predict handshakes from the pre-edge view, advance, then compare.
  task automatic step();
    bit push_fire, accept_fire, exp_start, ov_m;
    int lat;
    ov_m        = inflight && cyc >= rise_cyc;
    push_fire   = dut_if.in_valid && (fifo_m.size() < DEPTH);
    accept_fire = ov_m && dut_if.out_ready;
    exp_start   = !inflight && ena && fifo_m.size() != 0;
    @(posedge clk);
    #1;
    cyc++;
    if (accept_fire) inflight = 0;
    if (exp_start) begin
      cur       = fifo_m.pop_front();
      inflight  = 1;
      start_cyc = cyc;
      if (lat_q.size() != 0) lat = lat_q.pop_front();
      else if (rand_lat)     lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
      else                   lat = 1;
      exp_to      = (lat == 0);
      rise_cyc    = start_cyc + (exp_to ? TIMEOUT : lat) + 1;
      done_cyc    = exp_to ? -1 : start_cyc + lat;
      exp_data    = exp_to ? 8'hFF : alu_fn(cur);
      hold_cnt    = 0;
      ready_delay = rand_ready ? int'($urandom_range(0, 3)) : ready_delay_cfg;
    end
    if (push_fire) fifo_m.push_back(push_q.pop_front());
    if (inflight && exp_to && cyc == rise_cyc) err_m = 1;
    ov_m = inflight && cyc >= rise_cyc;

    checks++;
    if (dut_if.alu_start !== exp_start) begin
      errors++;
      $display("FAIL alu_start cyc=%0d got=%b exp=%b", cyc, dut_if.alu_start, exp_start);
    end
    if (inflight && cyc < rise_cyc) begin
      checks++;
      if ({dut_if.alu_a, dut_if.alu_b, dut_if.alu_op} !== cur) begin
        errors++;
        $display("FAIL alu_operands cyc=%0d got=%h exp=%h", cyc,
                 {dut_if.alu_a, dut_if.alu_b, dut_if.alu_op}, cur);
      end
    end
    checks++;
    if (dut_if.out_valid !== ov_m) begin
      errors++;
      $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, dut_if.out_valid, ov_m);
    end
    if (ov_m) begin
      checks++;
      if (dut_if.out_data !== exp_data) begin
        errors++;
        $display("FAIL out_data cyc=%0d got=%h exp=%h", cyc, dut_if.out_data, exp_data);
      end
    end
    checks++;
    if (fifo_count !== 3'(fifo_m.size())) begin
      errors++;
      $display("FAIL fifo_count cyc=%0d got=%0d exp=%0d", cyc, fifo_count, fifo_m.size());
    end
    checks++;
    if (dut_if.in_ready !== (fifo_m.size() < DEPTH)) begin
      errors++;
      $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, dut_if.in_ready, fifo_m.size() < DEPTH);
    end
    checks++;
    if (busy !== (inflight || fifo_m.size() != 0)) begin
      errors++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, inflight || fifo_m.size() != 0);
    end
    checks++;
    if (err_timeout !== err_m) begin
      errors++;
      $display("FAIL err_timeout cyc=%0d got=%b exp=%b", cyc, err_timeout, err_m);
    end
    drive_inputs();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive_inputs();
    @(posedge clk);
    #1;
    cyc++;
    push_q.delete(); fifo_m.delete(); lat_q.delete();
    inflight = 0; err_m = 0; done_cyc = -1; hold_cnt = 0;
    checks++;
    if ({dut_if.alu_start, dut_if.out_valid, err_timeout, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000", {dut_if.alu_start, dut_if.out_valid, err_timeout, busy});
    end
    checks++;
    if ({dut_if.alu_a, dut_if.alu_b, dut_if.alu_op, dut_if.out_data} !== 27'd0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0", {dut_if.alu_a, dut_if.alu_b, dut_if.alu_op, dut_if.out_data});
    end
    checks++;
    if (fifo_count !== 3'd0 || dut_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_fifo got count=%0d ready=%b exp count=0 ready=1", fifo_count, dut_if.in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic run_until_drained(input int max_cyc, input string tag);
    int n = 0;
    while ((push_q.size() != 0 || fifo_m.size() != 0 || inflight) && n < max_cyc) begin
      step();
      n++;
    end
    checks++;
    if (n >= max_cyc) begin
      errors++;
      $display("FAIL drain_%s got=%0d cycles exp<%0d", tag, n, max_cyc);
    end
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_single();
    trip_t t;
    ena = 1'b1;
    t = '{a: 8'd3, b: 8'd2, op: 3'd0};
    lat_q = '{1};
    push_q.push_back(t);
    drive_inputs();
    step();                                   // edge T: push
    step();                                   // edge T+1: issue
    checks++;
    if (dut_if.alu_start !== 1'b1) begin
      errors++;
      $display("FAIL single_start got=%b exp=1", dut_if.alu_start);
    end
    step();                                   // edge T+2: WAIT, done driven
    step();                                   // edge T+3: result
    checks++;
    if (dut_if.out_valid !== 1'b1 || dut_if.out_data !== 8'd5) begin
      errors++;
      $display("FAIL single_result got valid=%b data=%h exp valid=1 data=05",
               dut_if.out_valid, dut_if.out_data);
    end
    step();                                   // edge T+4: accepted
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got busy=%b exp=0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    lat_q = '{12};
    repeat (6) push_q.push_back(rand_trip());
    drive_inputs();
    while (push_q.size() > 1 && n < 20) begin step(); n++; end
    repeat (3) begin
      step();
      checks++;
      if (fifo_count !== 3'd4 || dut_if.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_full got count=%0d ready=%b exp count=4 ready=0", fifo_count, dut_if.in_ready);
      end
    end
    run_until_drained(300, "b2b");
  endtask

  task automatic test_hold_stall();
    int n = 0, m = 0;
    ready_delay_cfg = 10;
    lat_q = '{2, 1};
    repeat (2) push_q.push_back(rand_trip());
    drive_inputs();
    while (dut_if.out_valid !== 1'b1 && n < 50) begin step(); n++; end
    while (dut_if.out_valid === 1'b1 && m < 50) begin step(); m++; end
    checks++;
    if (m != 11) begin
      errors++;
      $display("FAIL hold_len got=%0d exp=11", m);
    end
    n = 0;
    while (dut_if.alu_start !== 1'b1 && n < 50) begin step(); n++; end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL hold_reissue got=%0d exp=1", n);
    end
    ready_delay_cfg = 0;
    run_until_drained(300, "hold");
  endtask

  task automatic test_timeout();
    int n = 0, m = 0;
    lat_q = '{0, 1};
    repeat (2) push_q.push_back(rand_trip());
    drive_inputs();
    while (dut_if.alu_start !== 1'b1 && n < 20) begin step(); n++; end
    while (dut_if.out_valid !== 1'b1 && m < 40) begin step(); m++; end
    checks++;
    if (m != TIMEOUT + 1) begin
      errors++;
      $display("FAIL timeout_latency got=%0d exp=%0d", m, TIMEOUT + 1);
    end
    checks++;
    if (dut_if.out_data !== 8'hFF || err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_result got data=%h err=%b exp data=ff err=1", dut_if.out_data, err_timeout);
    end
    run_until_drained(300, "timeout");
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky got=%b exp=1", err_timeout);
    end
  endtask

  task automatic test_reset_wait();
    int n = 0;
    lat_q = '{0};
    repeat (3) push_q.push_back(rand_trip());
    drive_inputs();
    while (dut_if.alu_start !== 1'b1 && n < 20) begin step(); n++; end
    repeat (3) step();
    checks++;
    if (fifo_count !== 3'd2) begin
      errors++;
      $display("FAIL rst_prequeue got=%0d exp=2", fifo_count);
    end
    apply_reset();
    drive_inputs();
    dut_if.alu_done = 1'b1;
    dut_if.alu_result = 8'h5A;
    step();
    checks++;
    if (dut_if.out_valid !== 1'b0 || busy !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL rst_late_done got valid=%b busy=%b count=%0d exp 0 0 0",
               dut_if.out_valid, busy, fifo_count);
    end
  endtask

  task automatic test_ena();
    int seen = 0;
    ena = 1'b0;
    repeat (2) push_q.push_back(rand_trip());
    drive_inputs();
    repeat (6) begin
      step();
      if (dut_if.alu_start === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || fifo_count !== 3'd2) begin
      errors++;
      $display("FAIL ena_block got starts=%0d count=%0d exp starts=0 count=2", seen, fifo_count);
    end
    ena = 1'b1;
    step();
    checks++;
    if (dut_if.alu_start !== 1'b1) begin
      errors++;
      $display("FAIL ena_issue got=%b exp=1", dut_if.alu_start);
    end
    run_until_drained(300, "ena");
  endtask

  task automatic test_random();
    noise_en = 1; gap_en = 1; rand_ena = 1; rand_ready = 1; rand_lat = 1;
    repeat (30) push_q.push_back(rand_trip());
    drive_inputs();
    run_until_drained(4000, "random");
    noise_en = 0; gap_en = 0; rand_ena = 0; rand_ready = 0; rand_lat = 0;
    ena = 1'b1;
    drive_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_stall();
    test_timeout();
    test_reset_wait();
    test_ena();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
